seven_segment: RTL and testbench
================================

# seven_segment

Registered hexadecimal-to-seven-segment decoder. It converts a 4-bit nibble on `data` into the seven segment-drive lines `segments` for a single display digit. It sits between the datapath and the display pins: one instance per digit, in the system clock domain. Output polarity is selectable so the block drives common-cathode or common-anode displays directly.

## Interface
- `COMMON_ANODE`, default 0: 0 = segment on is `1` (common cathode); 1 = every output bit inverted (common anode).
- `HEX_MODE`, default 1: 1 = codes 10–15 show A,b,C,d,E,F; 0 = codes 10–15 show blank (all segments off).
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `data`  input  4  nibble to display, unsigned 0–15.
- `blank`  input  1  1 = all segments off, regardless of `data`.
- `lamp_test`  input  1  present only with `SEVENSEG_LAMP_TEST_EN`; 1 = all segments on.
- `segments`  output  7  segment drive, bit order {a,b,c,d,e,f,g}: bit 6 = a (top), 5 = b, 4 = c, 3 = d, 2 = e, 1 = f, 0 = g (middle).

## Operation
- Combinational decode of `data` gives the active-high pattern P:
  - Digits 0–9: 0→7E, 1→30, 2→6D, 3→79, 4→33, 5→5B, 6→5F, 7→70, 8→7F, 9→7B.
  - Codes 10–15 with `HEX_MODE`=1: A→77, b→1F, C→4E, d→3D, E→4F, F→47.
  - Codes 10–15 with `HEX_MODE`=0: 00.
- Priority, highest first:
  - `rst_n`=0 gives 00.
  - `lamp_test`=1 (if compiled in) gives 7F.
  - `blank`=1 gives 00.
  - Otherwise P.
- The selected pattern is XORed with 7'h7F when `COMMON_ANODE`=1, then registered into `segments`.
- No X propagation: the decode is a full case over all 16 codes. There is no default-to-unknown.

## Timing
- One clock of latency: `data`, `blank` and `lamp_test` are sampled on a rising edge, and `segments` reflects them after that edge until the next edge.
- Reset value of `segments`: 7'h00 when `COMMON_ANODE`=0, 7'h7F when `COMMON_ANODE`=1 (display dark in both cases).
- Reset is synchronous. `rst_n` low at an edge forces the reset value at that edge. On the first edge with `rst_n` high, the output shows the current decode.
- Asserting reset mid-operation blanks the display at the next edge. No other state exists.
- Input changes between edges have no effect on `segments`, so the output is glitch-free.
- Simultaneous `blank`=1 and `lamp_test`=1: lamp test wins.

## Configuration
- `SEVENSEG_LAMP_TEST_EN` defined:
  - The `lamp_test` port exists.
  - When it is high, all seven segments are driven on (7F, or 00 for common anode) at the next edge.
- `SEVENSEG_LAMP_TEST_EN` undefined:
  - The port is absent.
  - Priority is reset, then `blank`, then decode.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with `data`=8 → `segments`=00 (`COMMON_ANODE`=0). Release → next edge gives 7F.
- Sweep: `data`=0..11, one value per edge (`HEX_MODE`=1, `blank`=0) → after each edge the output is 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F. Each value appears exactly one cycle after it is applied.
- Hex disable: `HEX_MODE`=0, `data`=10..15 → 00 every cycle. `data`=9 → 7B.
- Blank: `data`=5, `blank`=1 → 00. Drop `blank` → next edge gives 5B.
- Common anode: `COMMON_ANODE`=1, reset → 7F. Then `data`=0 → 01, `data`=1 → 4F.
- Lamp test (macro defined): `lamp_test`=1, `blank`=1, `data`=0 → 7F. Drop `lamp_test` → 00. Drop `blank` → 7E.

Source files
------------

// File: rtl/seven_segment.sv
`timescale 1ns/1ps
// seven_segment: registered hexadecimal-to-seven-segment decoder for one digit.
// Optional feature macro: SEVENSEG_LAMP_TEST_EN adds the lamp_test input.
// Segment bit order is {a,b,c,d,e,f,g}; bit 6 is segment a.
module seven_segment #(
  parameter bit COMMON_ANODE = 1'b0,
  parameter bit HEX_MODE     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data,
  input  logic       blank,
`ifdef SEVENSEG_LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  output logic [6:0] segments
);

  localparam int unsigned SEG_W = 7;
  localparam logic [SEG_W-1:0] ALL_ON   = SEG_W'(7'h7f);
  localparam logic [SEG_W-1:0] ALL_OFF  = SEG_W'(7'h00);
  // Inverting mask applied to every driven pattern, including the reset value.
  localparam logic [SEG_W-1:0] POL_MASK = COMMON_ANODE ? ALL_ON : ALL_OFF;

  logic [SEG_W-1:0] pattern_c;
  logic [SEG_W-1:0] select_c;

  // Active-high glyph for every nibble value; letters collapse to blank when hex is disabled.
  always_comb begin
    pattern_c = ALL_OFF;
    case (data)
      4'h0: pattern_c = SEG_W'(7'h7e);
      4'h1: pattern_c = SEG_W'(7'h30);
      4'h2: pattern_c = SEG_W'(7'h6d);
      4'h3: pattern_c = SEG_W'(7'h79);
      4'h4: pattern_c = SEG_W'(7'h33);
      4'h5: pattern_c = SEG_W'(7'h5b);
      4'h6: pattern_c = SEG_W'(7'h5f);
      4'h7: pattern_c = SEG_W'(7'h70);
      4'h8: pattern_c = SEG_W'(7'h7f);
      4'h9: pattern_c = SEG_W'(7'h7b);
      4'ha: pattern_c = HEX_MODE ? SEG_W'(7'h77) : ALL_OFF;
      4'hb: pattern_c = HEX_MODE ? SEG_W'(7'h1f) : ALL_OFF;
      4'hc: pattern_c = HEX_MODE ? SEG_W'(7'h4e) : ALL_OFF;
      4'hd: pattern_c = HEX_MODE ? SEG_W'(7'h3d) : ALL_OFF;
      4'he: pattern_c = HEX_MODE ? SEG_W'(7'h4f) : ALL_OFF;
      4'hf: pattern_c = HEX_MODE ? SEG_W'(7'h47) : ALL_OFF;
    endcase
  end

  // Override priority: lamp test above blank above the decoded glyph.
  always_comb begin
    select_c = pattern_c;
`ifdef SEVENSEG_LAMP_TEST_EN
    if (lamp_test) begin
      select_c = ALL_ON;
    end else if (blank) begin
      select_c = ALL_OFF;
    end
`else
    if (blank) begin
      select_c = ALL_OFF;
    end
`endif
  end

  // Output register with synchronous reset to a dark display in either polarity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      segments <= POL_MASK;
    end else begin
      segments <= select_c ^ POL_MASK;
    end
  end

endmodule

// File: tb/tb_seven_segment.sv
`timescale 1ns/1ps
// tb_seven_segment: randomized and directed checks of three decoder configurations
// against a segment-letter reference model. Honours SEVENSEG_LAMP_TEST_EN.
module tb_seven_segment;

`ifdef SEVENSEG_LAMP_TEST_EN
  localparam bit LT_EN = 1'b1;
`else
  localparam bit LT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] data;
  logic       blank;
  logic       lamp_test;
  logic [6:0] seg_cc_hex;
  logic [6:0] seg_cc_dec;
  logic [6:0] seg_ca_hex;

  int checks;
  int failures;

  seven_segment #(.COMMON_ANODE(1'b0), .HEX_MODE(1'b1)) u_cc_hex (
    .clk(clk), .rst_n(rst_n), .data(data), .blank(blank),
`ifdef SEVENSEG_LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .segments(seg_cc_hex)
  );

  seven_segment #(.COMMON_ANODE(1'b0), .HEX_MODE(1'b0)) u_cc_dec (
    .clk(clk), .rst_n(rst_n), .data(data), .blank(blank),
`ifdef SEVENSEG_LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .segments(seg_cc_dec)
  );

  seven_segment #(.COMMON_ANODE(1'b1), .HEX_MODE(1'b1)) u_ca_hex (
    .clk(clk), .rst_n(rst_n), .data(data), .blank(blank),
`ifdef SEVENSEG_LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .segments(seg_ca_hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lit segments per glyph, spelled as segment letters.
  string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] letters_to_bits(input string s);
    logic [6:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) begin
      v[6 - (int'(s[i]) - int'("a"))] = 1'b1;
    end
    return v;
  endfunction

  // Expected register contents after an edge that sampled the given inputs.
  function automatic logic [6:0] model(input bit ca, input bit hex, input bit rn,
                                       input bit lt, input bit blk, input int d);
    logic [6:0] lit;
    if (!rn)                lit = '0;
    else if (LT_EN && lt)   lit = 7'h7f;
    else if (blk)           lit = '0;
    else if (d > 9 && !hex) lit = '0;
    else                    lit = letters_to_bits(glyph[d]);
    return ca ? ~lit : lit;
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Apply inputs, clock once, then compare all three instances against the model.
  task automatic step(input string tag, input bit rn, input int d, input bit blk, input bit lt);
    logic [6:0] e_cc_hex, e_cc_dec, e_ca_hex;
    rst_n = rn; data = 4'(d); blank = blk; lamp_test = lt;
    e_cc_hex = model(1'b0, 1'b1, rn, lt, blk, d);
    e_cc_dec = model(1'b0, 1'b0, rn, lt, blk, d);
    e_ca_hex = model(1'b1, 1'b1, rn, lt, blk, d);
    @(posedge clk);
    #1;
    check({tag, "/cc_hex"}, seg_cc_hex, e_cc_hex);
    check({tag, "/cc_dec"}, seg_cc_dec, e_cc_dec);
    check({tag, "/ca_hex"}, seg_ca_hex, e_ca_hex);
  endtask

  initial begin
    logic [6:0] held;
    checks = 0; failures = 0;
    rst_n = 1'b0; data = 4'd8; blank = 1'b0; lamp_test = 1'b0;

    // Reset held for two edges with data=8, then release.
    step("rst0", 1'b0, 8, 1'b0, 1'b0);
    check("rst_cc_const", seg_cc_hex, 7'h00);
    check("rst_ca_const", seg_ca_hex, 7'h7f);
    step("rst1", 1'b0, 8, 1'b0, 1'b0);
    step("rel", 1'b1, 8, 1'b0, 1'b0);
    check("rel_const", seg_cc_hex, 7'h7f);

    // Sweep all codes, one per edge.
    for (int d = 0; d < 16; d++) step($sformatf("sweep%0d", d), 1'b1, d, 1'b0, 1'b0);
    step("dec9", 1'b1, 9, 1'b0, 1'b0);
    check("dec9_const", seg_cc_dec, 7'h7b);
    step("hexA", 1'b1, 10, 1'b0, 1'b0);
    check("hexA_cc_const", seg_cc_hex, 7'h77);
    check("hexA_dec_const", seg_cc_dec, 7'h00);

    // Blank then release.
    step("blank5", 1'b1, 5, 1'b1, 1'b0);
    step("unblank5", 1'b1, 5, 1'b0, 1'b0);
    check("unblank5_const", seg_cc_hex, 7'h5b);

    // Common anode digits 0 and 1.
    step("ca0", 1'b1, 0, 1'b0, 1'b0);
    check("ca0_const", seg_ca_hex, 7'h01);
    step("ca1", 1'b1, 1, 1'b0, 1'b0);
    check("ca1_const", seg_ca_hex, 7'h4f);

    // Lamp test over blank (only meaningful when compiled in).
    step("lt_on", 1'b1, 0, 1'b1, 1'b1);
    step("lt_off", 1'b1, 0, 1'b1, 1'b0);
    step("blank_off", 1'b1, 0, 1'b0, 1'b0);

    // Mid-operation reset darkens display at the next edge.
    step("pre_rst", 1'b1, 3, 1'b0, 1'b0);
    step("mid_rst", 1'b0, 3, 1'b0, 1'b0);
    step("post_rst", 1'b1, 3, 1'b0, 1'b0);

    // Randomized traffic, plus inputs wiggled between edges must not move the output.
    for (int i = 0; i < 300; i++) begin
      step($sformatf("rnd%0d", i), ($urandom_range(0, 19) != 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
      if (i % 10 == 0) begin
        held = seg_cc_hex;
        data = 4'($urandom_range(0, 15)); blank = ~blank; rst_n = ~rst_n;
        #2;
        check($sformatf("hold%0d", i), seg_cc_hex, held);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
